// File: rtl/tour_cost_sequencer_if.sv
// tour_cost_sequencer_if: start/result, tour/city RAM and distance-unit signals of the tour cost sequencer.
interface tour_cost_sequencer_if #(
    parameter int IDX_W = 6,
    parameter int ACC_W = 40
);
    logic             start;
    logic [IDX_W:0]   num_cities;
    logic             busy;
    logic             done;
    logic [ACC_W-1:0] total;
    logic [IDX_W-1:0] tour_addr;
    logic [IDX_W-1:0] tour_data;
    logic [IDX_W-1:0] city_addr;
    logic [63:0]      city_data;
    logic             dist_valid;
    logic [63:0]      dist_citya;
    logic [63:0]      dist_cityb;
    logic             dist_res_valid;
    logic [31:0]      dist_res;
    modport master (
        output start, num_cities, tour_data, city_data, dist_res_valid, dist_res,
        input  busy, done, total, tour_addr, city_addr, dist_valid, dist_citya, dist_cityb
    );
    modport slave (
        input  start, num_cities, tour_data, city_data, dist_res_valid, dist_res,
        output busy, done, total, tour_addr, city_addr, dist_valid, dist_citya, dist_cityb
    );
endinterface

// File: rtl/tour_cost_sequencer.sv
// tour_cost_sequencer: walks a tour through the tour/city RAMs, streams city pairs to the
// distance unit and accumulates the returned distances into a saturating closed-tour total.
module tour_cost_sequencer #(
    parameter int IDX_W = 6,
    parameter int ACC_W = 40
) (
    input logic                 clk,
    input logic                 rst,
    tour_cost_sequencer_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2, FINISH = 2'd3;
    localparam logic [IDX_W:0] N_MAX = {1'b1, {IDX_W{1'b0}}};
    localparam logic [IDX_W:0] ONE = {{IDX_W{1'b0}}, 1'b1};
    logic [1:0]       state_q, state_d;
    logic [IDX_W:0]   n_q, n_d, k_q, k_d, cnt_q, cnt_d, n_in;
    logic             short_q, short_d;
    logic             v1_q, v1_d, f1_q, f1_d, v2_q, v2_d, f2_q, f2_d;
    logic [63:0]      prev_q, prev_d, ca_q, ca_d, cb_q, cb_d;
    logic             dv_q, dv_d;
    logic [ACC_W-1:0] total_q, total_d;
    logic [ACC_W:0]   sum;
    logic             accept, res_ok;
    always_comb begin
        n_in    = bus.num_cities > N_MAX ? N_MAX : bus.num_cities;
        accept  = state_q == IDLE && bus.start;
        res_ok  = bus.dist_res_valid && (state_q == FETCH || state_q == DRAIN);
        sum     = {1'b0, total_q} + {{(ACC_W-31){1'b0}}, bus.dist_res};
        cnt_d   = accept ? '0 : (res_ok ? cnt_q + ONE : cnt_q);
        total_d = accept ? '0 : (res_ok ? (sum[ACC_W] ? '1 : sum[ACC_W-1:0]) : total_q);
        n_d     = accept ? n_in : n_q;
        k_d     = accept ? '0 : (state_q == FETCH ? k_q + ONE : k_q);
        // a short run spends one extra FINISH cycle so done lands two cycles after start
        short_d = accept && n_in[IDX_W:1] == '0;
        state_d = state_q == IDLE  ? (bus.start ? (n_in[IDX_W:1] == '0 ? FINISH : FETCH) : IDLE)
                : state_q == FETCH ? (k_q == n_q ? DRAIN : FETCH)
                : state_q == DRAIN ? (cnt_d == n_q ? FINISH : DRAIN)
                : (short_q ? FINISH : IDLE);
        // two stages cover the tour-RAM and city-RAM read latencies
        v1_d    = state_q == FETCH;
        f1_d    = k_q == '0;
        v2_d    = v1_q;
        f2_d    = f1_q;
        prev_d  = v2_q ? bus.city_data : prev_q;
        dv_d    = v2_q && !f2_q;
        ca_d    = dv_d ? prev_q : ca_q;
        cb_d    = dv_d ? bus.city_data : cb_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            short_q <= 1'b0;
            v1_q    <= 1'b0;
            f1_q    <= 1'b0;
            v2_q    <= 1'b0;
            f2_q    <= 1'b0;
            prev_q  <= '0;
            dv_q    <= 1'b0;
            ca_q    <= '0;
            cb_q    <= '0;
            total_q <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            short_q <= short_d;
            v1_q    <= v1_d;
            f1_q    <= f1_d;
            v2_q    <= v2_d;
            f2_q    <= f2_d;
            prev_q  <= prev_d;
            dv_q    <= dv_d;
            ca_q    <= ca_d;
            cb_q    <= cb_d;
            total_q <= total_d;
        end
    end
    assign bus.tour_addr  = (state_q == FETCH && k_q != n_q) ? k_q[IDX_W-1:0] : '0;
    assign bus.city_addr  = bus.tour_data;
    assign bus.busy       = state_q != IDLE;
    assign bus.done       = state_q == FINISH && !short_q;
    assign bus.total      = total_q;
    assign bus.dist_valid = dv_q;
    assign bus.dist_citya = ca_q;
    assign bus.dist_cityb = cb_q;
endmodule

// File: tb/tb_tour_cost_sequencer.sv
// tb_tour_cost_sequencer: table-driven and hand-sequenced checks of the tour cost sequencer
// against RAM models and an in-order Manhattan distance unit with configurable latency.
module tb_tour_cost_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0, errors = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tour_cost_sequencer_if #(.IDX_W(6), .ACC_W(40)) bus ();
    tour_cost_sequencer_if #(.IDX_W(6), .ACC_W(33)) b33 ();
    tour_cost_sequencer #(.IDX_W(6), .ACC_W(40)) dut (.clk(clk), .rst(rst), .bus(bus));
    tour_cost_sequencer #(.IDX_W(6), .ACC_W(33)) dut33 (.clk(clk), .rst(rst), .bus(b33));
    assign b33.start          = bus.start;
    assign b33.num_cities     = bus.num_cities;
    assign b33.tour_data      = bus.tour_data;
    assign b33.city_data      = bus.city_data;
    assign b33.dist_res_valid = bus.dist_res_valid;
    assign b33.dist_res       = bus.dist_res;

    logic [5:0]  tour_mem [64];
    logic [63:0] city_mem [64];
    always @(posedge clk) begin
        bus.tour_data <= tour_mem[bus.tour_addr];
        bus.city_data <= city_mem[bus.city_addr];
    end

    function automatic logic [31:0] mdist(input logic [63:0] a, input logic [63:0] b);
        logic [31:0] dx, dy;
        dx = a[31:0] > b[31:0] ? a[31:0] - b[31:0] : b[31:0] - a[31:0];
        dy = a[63:32] > b[63:32] ? a[63:32] - b[63:32] : b[63:32] - a[63:32];
        return dx + dy;
    endfunction

    // distance unit: in-order, one result per cycle, latency lat_lo..lat_hi
    int          due_q [$];
    logic [31:0] val_q [$];
    int          lat_lo = 1, lat_hi = 1, last_res = -1;
    bit          sat = 1'b0;
    always @(negedge clk) begin
        int d;
        if (bus.dist_valid) begin
            d = cyc + int'($urandom_range(lat_hi, lat_lo));
            if (due_q.size() > 0 && d <= due_q[due_q.size()-1]) d = due_q[due_q.size()-1] + 1;
            due_q.push_back(d);
            val_q.push_back(sat ? 32'hFFFF_FFFF : mdist(bus.dist_citya, bus.dist_cityb));
        end
        if (due_q.size() > 0 && due_q[0] <= cyc) begin
            bus.dist_res_valid = 1'b1;
            bus.dist_res = val_q.pop_front();
            void'(due_q.pop_front());
            last_res = cyc;
        end else begin
            bus.dist_res_valid = 1'b0;
            bus.dist_res = '0;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    function automatic logic [39:0] model_total(input int n);
        logic [39:0] t = '0;
        for (int k = 0; k < n; k++)
            t += 40'(mdist(city_mem[tour_mem[k]], city_mem[tour_mem[(k+1)%n]]));
        return t;
    endfunction

    task automatic load_square();
        city_mem[0] = {32'd0, 32'd0};
        city_mem[1] = {32'd0, 32'd3};
        city_mem[2] = {32'd4, 32'd3};
        city_mem[3] = {32'd4, 32'd0};
    endtask

    task automatic run(input logic [6:0] num, input int lo, input int hi,
                       input logic [39:0] exp, input bit poke);
        int s, n, np, dcyc, first, last, bad_addr, bad_pair, k;
        logic [63:0] ea, eb;
        n = num > 7'd64 ? 64 : (num < 7'd2 ? 0 : int'(num));
        lat_lo = lo;
        lat_hi = hi;
        bus.num_cities = num;
        bus.start = 1'b1;
        s = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_after_start", {63'd0, bus.busy}, 64'd1);
        np = 0; dcyc = -1; first = -1; last = -1; bad_addr = 0; bad_pair = 0;
        while (dcyc < 0 && cyc < s + 400) begin
            k = cyc - s - 1;
            if (n > 0 && k <= n && bus.tour_addr != 6'(k < n ? k : 0)) bad_addr++;
            if (poke) begin
                if (cyc == s + 10) begin bus.start = 1'b1; bus.num_cities = 7'd5; end
                if (cyc == s + 11) bus.start = 1'b0;
            end
            if (bus.dist_valid) begin
                if (np < n) begin
                    ea = city_mem[tour_mem[np]];
                    eb = city_mem[tour_mem[(np+1)%n]];
                    if (bus.dist_citya != ea || bus.dist_cityb != eb) bad_pair++;
                end
                if (first < 0) first = cyc;
                last = cyc;
                np++;
            end
            if (bus.done) dcyc = cyc;
            @(negedge clk);
        end
        chk("pair_count", 64'(np), 64'(n));
        chk("first_pair_cycle", 64'(first), 64'(n > 0 ? s + 5 : -1));
        chk("last_pair_cycle", 64'(last), 64'(n > 0 ? s + 4 + n : -1));
        chk("pair_data_errors", 64'(bad_pair), 64'd0);
        chk("tour_addr_errors", 64'(bad_addr), 64'd0);
        chk("done_cycle", 64'(dcyc), 64'(n > 0 ? last_res + 1 : s + 2));
        chk("done_one_pulse", {63'd0, bus.done}, 64'd0);
        chk("busy_after_done", {63'd0, bus.busy}, 64'd0);
        chk("total", 64'(bus.total), 64'(exp));
    endtask

    typedef struct {
        logic [6:0]  n;
        logic [5:0]  t [4];
        int          lat;
        logic [39:0] exp;
    } vec_t;
    vec_t vt [6];

    initial begin
        int s, bad, j;
        logic [5:0] tmp;
        vt[0] = '{7'd4, '{6'd0, 6'd1, 6'd2, 6'd3}, 3, 40'd14};
        vt[1] = '{7'd3, '{6'd2, 6'd0, 6'd1, 6'd0}, 1, 40'd14};
        vt[2] = '{7'd0, '{6'd0, 6'd1, 6'd2, 6'd3}, 1, 40'd0};
        vt[3] = '{7'd1, '{6'd0, 6'd1, 6'd2, 6'd3}, 1, 40'd0};
        vt[4] = '{7'd2, '{6'd0, 6'd1, 6'd2, 6'd3}, 5, 40'd6};
        vt[5] = '{7'd4, '{6'd0, 6'd2, 6'd1, 6'd3}, 2, 40'd22};
        for (int i = 0; i < 64; i++) begin tour_mem[i] = 6'(i); city_mem[i] = '0; end
        load_square();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.num_cities = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_done", {63'd0, bus.done}, 64'd0);
        chk("rst_dist_valid", {63'd0, bus.dist_valid}, 64'd0);
        chk("rst_total", 64'(bus.total), 64'd0);
        chk("rst_tour_addr", 64'(bus.tour_addr), 64'd0);

        for (int i = 0; i < 6; i++) begin
            for (int t = 0; t < 4; t++) tour_mem[t] = vt[i].t[t];
            run(vt[i].n, vt[i].lat, vt[i].lat, vt[i].exp, 1'b0);
        end

        for (int t = 0; t < 4; t++) tour_mem[t] = 6'(t);
        sat = 1'b1;
        run(7'd4, 2, 2, 40'h3_FFFF_FFFC, 1'b0);
        chk("total_sat33", 64'(b33.total), 64'h1_FFFF_FFFF);
        sat = 1'b0;

        for (int i = 0; i < 64; i++) begin
            city_mem[i] = {32'($urandom_range(999)), 32'($urandom_range(999))};
            tour_mem[i] = 6'(i);
        end
        for (int i = 63; i > 0; i--) begin
            j = int'($urandom_range(i));
            tmp = tour_mem[i]; tour_mem[i] = tour_mem[j]; tour_mem[j] = tmp;
        end
        run(7'd64, 1, 20, model_total(64), 1'b1);
        run(7'd100, 1, 3, model_total(64), 1'b0);

        // reset while results are still outstanding in DRAIN
        lat_lo = 20; lat_hi = 20;
        bus.num_cities = 7'd64;
        bus.start = 1'b1;
        s = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        while (cyc < s + 70) @(negedge clk);
        chk("drain_busy", {63'd0, bus.busy}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("mid_rst_done", {63'd0, bus.done}, 64'd0);
        chk("mid_rst_dist_valid", {63'd0, bus.dist_valid}, 64'd0);
        chk("mid_rst_total", 64'(bus.total), 64'd0);
        chk("mid_rst_tour_addr", 64'(bus.tour_addr), 64'd0);
        chk("mid_rst_citya", bus.dist_citya, 64'd0);
        chk("mid_rst_cityb", bus.dist_cityb, 64'd0);
        chk("stale_pending", 64'(due_q.size() > 0), 64'd1);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.dist_valid || bus.done || bus.busy) bad++;
            @(negedge clk);
        end
        for (int i = 0; i < 100 && due_q.size() > 0; i++) @(negedge clk);
        chk("stale_activity", 64'(bad), 64'd0);
        chk("stale_total", 64'(bus.total), 64'd0);
        chk("stale_drained", 64'(due_q.size()), 64'd0);

        load_square();
        for (int t = 0; t < 4; t++) tour_mem[t] = vt[0].t[t];
        run(vt[0].n, 4, 4, vt[0].exp, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tour_cost_sequencer.md
# tour_cost_sequencer

Computes the closed-tour length of a TSP candidate for the simulated-annealing core. It walks a tour-order RAM (position → city index), fetches coordinates from the city RAM, and streams consecutive city pairs into the pipelined `distance` unit, one pair per cycle. It then accumulates the returned distances into a single total. It is the sole driver of the `distance` unit's input port and sits between the annealing controller and that unit.

## Interface
- `IDX_W`, default 6: city index / tour position width; maximum 2^IDX_W cities.
- `ACC_W`, default 40: accumulator width.
- `clk`, in, 1: clock.
- `rst`, in, 1: reset; synchronous, active-high.
- `start`, in, 1: begin evaluation; sampled only in IDLE.
- `num_cities`, in, IDX_W+1: tour length n; sampled with `start`.
- `busy`, out, 1: high from the cycle after accepted `start` until `done`, inclusive.
- `done`, out, 1: one-cycle pulse; `total` is valid.
- `total`, out, ACC_W: tour length, saturating.
- `tour_addr`, out, IDX_W: tour RAM read address; the RAM has a 1-cycle registered read.
- `tour_data`, in, IDX_W: city index read from the tour RAM.
- `city_addr`, out, IDX_W: city RAM address, driven combinationally from `tour_data`.
- `city_data`, in, 64: {Y[63:32], X[31:0]}; the city RAM has a 1-cycle registered read.
- `dist_valid`, out, 1: pair valid to the `distance` unit.
- `dist_citya`, out, 64: previous city of the pair.
- `dist_cityb`, out, 64: current city of the pair.
- `dist_res_valid`, in, 1: result valid from the `distance` unit.
- `dist_res`, in, 32: distance result.

## Operation
- States:
  - IDLE: `start` moves to FETCH if n≥2, or to FINISH if n≤1.
  - FETCH: issues tour positions k=0..n, then moves to DRAIN.
  - DRAIN: waits until the result counter equals n, then moves to FINISH.
  - FINISH: pulses `done`, then returns to IDLE.
- Address generation:
  - FETCH issues `tour_addr` = k for k<n and 0 for k=n (wrap-around closes the tour). This is n+1 addresses on consecutive cycles.
  - A 2-deep valid/step pipeline tracks the RAM latency.
  - The coordinate of step 0 is only latched as "previous".
  - For each step k≥1, a pair is emitted: `dist_citya` = coordinate of step k-1, `dist_cityb` = coordinate of step k, `dist_valid`=1. The current coordinate then becomes "previous".
  - Exactly n pairs are issued per run.
- Result handling:
  - Results are counted, not timed; the controller tolerates any `distance` latency.
  - On each `dist_res_valid` in FETCH or DRAIN: `total` ← min(`total` + zero-extended `dist_res`, 2^ACC_W−1), and the result counter increments.
  - A result and a pair issue in the same cycle are both handled.
- Clearing and holding:
  - `total` clears to 0 on accepted `start`.
  - `total` holds its value after `done` until the next accepted `start`.
  - n≤1: no RAM reads, no pairs issued, `total`=0.
  - n > 2^IDX_W is clamped to 2^IDX_W.
- Ignored inputs:
  - `start` while `busy` is ignored.
  - `dist_res_valid` in IDLE or FINISH is ignored, as are stale results after reset.
- Reset values:
  - State = IDLE.
  - `busy`, `done`, `dist_valid` = 0.
  - `total` = 0.
  - `tour_addr` = 0.
  - `dist_citya`, `dist_cityb` = 0.
  - Counters = 0.
- Reset mid-run aborts immediately; no further `dist_valid` is issued.

## Timing
- `start` is high in cycle S (IDLE).
- `busy`=1 from cycle S+1.
- `tour_addr`=k in cycle S+1+k.
- `tour_data`/`city_addr` for step k in cycle S+2+k.
- `city_data` for step k in cycle S+3+k.
- `dist_valid` is high in cycles S+5 .. S+4+n, contiguous and registered.
- With a `distance` latency of L cycles from `dist_valid` to `dist_res_valid`, the last result arrives at S+4+n+L. `done` is high one cycle later, and `busy` drops the cycle after `done`.
- n≤1: `done` at S+2.
- Throughput: one pair per cycle. Back-to-back runs are possible one cycle after `done`.

## Test plan
- Square tour, n=4: cities (0,0),(3,0),(3,4),(0,4), tour order 0,1,2,3. Expect pairs 0→1, 1→2, 2→3, 3→0 on 4 consecutive cycles starting at S+5, then `total`=14 and one `done` pulse.
- Wrap check, n=3: tour order 2,0,1. Expect the last pair to be city1→city2 and `tour_addr` sequence 0,1,2,0.
- n=0 and n=1: expect no `dist_valid`, `done` at S+2, `total`=0.
- Model the `distance` unit with a random latency of 1–20 cycles, keeping responses in order, for n=64. Expect exactly 64 pairs, `total` equal to the software model, and `start` pulses while `busy` ignored.
- Force `dist_res`=0xFFFFFFFF with ACC_W=33 for n=4. Expect `total` to saturate at 2^33−1.
- Assert `rst` mid-DRAIN with results still pending. Expect IDLE with all outputs at reset values, late `dist_res_valid` ignored, and a following run correct.
